fp_sum_sched: RTL and testbench
===============================

Name: fp_sum_sched

Overview:
- Two-requester scheduler in front of a shared fixed-point adder datapath.
- Arbitrates operand pairs (A S(16,14), B S(12,10)) round-robin and aligns B to A.
- Computes the full-precision S(17,14) sum, then formats it to S(11,10) by wrap-truncate, truncate+saturate or round+saturate, selected per request.
- Sits between operand producers and any consumer of adder results; two-stage pipeline with valid/ready on both sides.

Parameters:
- NB_A, 16, total bits of operand A
- NBF_A, 14, fractional bits of A
- NB_B, 12, total bits of operand B
- NBF_B, 10, fractional bits of B
- NB_OUT, 11, total bits of formatted result
- NBF_OUT, 10, fractional bits of formatted result

Ports:
- clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous reset, active-high
- i_valid0 / i_valid1  in  1  requester 0/1 operand pair valid
- o_ready0 / o_ready1  out  1  requester 0/1 accepted this cycle when valid&ready
- i_a0 / i_a1  in  NB_A  signed operand A per requester
- i_b0 / i_b1  in  NB_B  signed operand B per requester
- i_mode0 / i_mode1  in  2  00 = truncate+wrap, 01 = truncate+saturate, 10/11 = round+saturate
- o_valid  out  1  result valid
- i_out_ready  in  1  consumer accepts result
- o_result  out  NB_OUT  formatted signed result
- o_full  out  NB_A+1  unformatted S(17,14) sum
- o_ovf  out  1  integer range exceeded before formatting
- o_id  out  1  requester that issued this result

Behaviour:
- Reset (async, immediate): all valid flags 0, o_result/o_full/o_ovf/o_id = 0, RR pointer = 0 (requester 0 preferred).
- stall = o_valid & ~i_out_ready. The pipeline advances only when ~stall; this is a single global enable.
- Arbitration (combinational):
  - Only i_valid0: grant 0. Only i_valid1: grant 1.
  - Both valid: grant the requester the pointer prefers.
  - o_readyN = grantN & ~stall. At most one ready per cycle.
  - On accept the pointer moves to prefer the other requester; with no accept it holds.
- Stage 1 (register, cycle after accept):
  - b_al = sign-extend(B) << (NBF_A-NBF_B).
  - sum = A + b_al, NB_A+1 bits, never overflows.
  - Registers sum, mode, id and s1_valid.
- Stage 2 (register, second cycle after accept):
  - Drop D = NBF_A-NBF_OUT = 4 LSBs.
  - Truncate: t = sum >>> D (arithmetic).
  - Round: r = (sum + 2^(D-1)) >>> D, half-up, computed one bit wider.
  - ovf = the value selected by mode (t or r) is outside [-2^(NB_OUT-1), 2^(NB_OUT-1)-1].
  - Mode 00: o_result = low NB_OUT bits of t (wrap); ovf still reported.
  - Mode 01/10/11: saturate to 0x3FF or 0x400 on ovf.
  - o_full = sum, o_id = id, o_valid = s1_valid.
- Latency: accept at edge N gives o_valid at edge N+2. Throughput 1 per cycle when not stalled.
- Stall: o_result, o_full, o_ovf, o_id and stage-1 contents are held stable; both readies are 0.
- Bubbles: an empty stage 1 propagates o_valid=0 when not stalled.
- Reset mid-operation discards all in-flight results; no partial output.

Optional Feature:
- FP_SUM_STATS_EN defined: adds o_ovf_cnt (16 bits, out).
  - Increments on each result handshake (o_valid & i_out_ready) with o_ovf=1.
  - Saturates at 0xFFFF; reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fp_sum_pkg holds:
  - mode localparams MODE_TRUNC = 2'b00, MODE_TSAT = 2'b01, MODE_RSAT = 2'b10;
  - derived widths NB_SUM = NB_A+1, SHIFT_B = NBF_A-NBF_B, DROP = NBF_A-NBF_OUT;
  - saturation constants SAT_MAX / SAT_MIN.
- One sub-module, fp_fmt_sat: purely combinational truncate/round/saturate of NB_SUM to NB_OUT with ovf flag. Instantiated in stage 2. Arbiter and pipeline live in the top.

Test Plan:
- req0 A=28672, B=512, each mode in turn, i_out_ready=1 -> o_full=36864, o_ovf=1; mode00 o_result=256, mode01 1023, mode10 1023, each 2 cycles after accept, o_id=0.
- req1 A=1000, B=3 -> o_full=1048; mode00/01 o_result=65, mode10 o_result=66, o_ovf=0, o_id=1.
- A=-32768, B=-2048 -> o_full=-65536, o_ovf=1; mode00 o_result=0, mode01/10 o_result=-1024 (0x400).
- Both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 and o_id follows the same sequence.
- i_out_ready=0 for 3 cycles with a result pending -> o_result/o_id stable, o_ready0/1=0, no loss; release -> results in order.
- Assert i_reset while two results are in flight -> o_valid=0 immediately and pointer back to 0; with FP_SUM_STATS_EN, o_ovf_cnt back to 0.

Source files
------------

// File: rtl/fp_sum_pkg.sv
// Shared widths, mode codes and saturation limits for the fp_sum_sched adder slice.
// Pure declarations: no logic, no latency, no flow control.
package fp_sum_pkg;
  localparam int NB_A     = 16;
  localparam int NBF_A    = 14;
  localparam int NB_B     = 12;
  localparam int NBF_B    = 10;
  localparam int NB_OUT   = 11;
  localparam int NBF_OUT  = 10;

  localparam int NB_SUM   = NB_A + 1;
  localparam int SHIFT_B  = NBF_A - NBF_B;
  localparam int DROP     = NBF_A - NBF_OUT;
  localparam int NB_TRUNC = NB_SUM - DROP;
  localparam int NB_RND   = NB_TRUNC + 1;

  localparam logic [1:0] MODE_TRUNC = 2'b00;
  localparam logic [1:0] MODE_TSAT  = 2'b01;
  localparam logic [1:0] MODE_RSAT  = 2'b10;

  localparam logic [NB_OUT-1:0] SAT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic [NB_OUT-1:0] SAT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

  typedef enum logic {PREF_0 = 1'b0, PREF_1 = 1'b1} rr_t;

  typedef struct packed {
    logic [NB_SUM-1:0] sum;
    logic [1:0]        mode;
    logic              id;
  } s1_t;
endpackage

// File: rtl/fp_fmt_sat.sv
// Formats an S(17,14) sum to S(11,10): wrap-truncate, truncate+saturate or round+saturate.
// Purely combinational, zero latency, no flow control.
module fp_fmt_sat
  import fp_sum_pkg::*;
(
  input  logic [NB_SUM-1:0] sum,
  input  logic [1:0]        mode,
  output logic [NB_OUT-1:0] result,
  output logic              ovf
);
  logic [NB_TRUNC-1:0] t;
  logic [NB_SUM:0]     sum_rnd;
  logic [NB_RND-1:0]   r;
  logic [NB_RND-1:0]   sel;

  assign t       = NB_TRUNC'($signed(sum) >>> DROP);
  // One extra bit so the half-LSB add cannot wrap at the positive end.
  assign sum_rnd = {sum[NB_SUM-1], sum} + ((NB_SUM+1)'(1) << (DROP-1));
  assign r       = NB_RND'($signed(sum_rnd) >>> DROP);
  assign sel     = mode[1] ? r : {t[NB_TRUNC-1], t};

  // In range only when every bit above the output sign bit matches it.
  assign ovf = ~((&sel[NB_RND-1:NB_OUT-1]) | ~(|sel[NB_RND-1:NB_OUT-1]));

  always_comb begin
    result = sel[NB_OUT-1:0];
    if (mode == MODE_TRUNC) begin
      result = t[NB_OUT-1:0];
    end else if (ovf) begin
      result = sel[NB_RND-1] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/fp_sum_sched.sv
// Round-robin two-requester scheduler feeding an aligned S(17,14) adder and an S(11,10) formatter.
// Latency 2 cycles accept-to-valid, 1 result/cycle; a held output stalls both stages and drops both readies.
// FP_SUM_STATS_EN adds a saturating 16-bit count of overflowing results taken by the consumer (o_ovf_cnt).
module fp_sum_sched
  import fp_sum_pkg::*;
(
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_valid0,
  input  logic              i_valid1,
  output logic              o_ready0,
  output logic              o_ready1,
  input  logic [NB_A-1:0]   i_a0,
  input  logic [NB_A-1:0]   i_a1,
  input  logic [NB_B-1:0]   i_b0,
  input  logic [NB_B-1:0]   i_b1,
  input  logic [1:0]        i_mode0,
  input  logic [1:0]        i_mode1,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic [NB_OUT-1:0] o_result,
  output logic [NB_SUM-1:0] o_full,
  output logic              o_ovf,
`ifdef FP_SUM_STATS_EN
  output logic [15:0]       o_ovf_cnt,
`endif
  output logic              o_id
);
  rr_t               ptr, ptr_nxt;
  logic              grant0, grant1, accept, stall;
  logic [NB_A-1:0]   a_sel, b_al;
  logic [NB_B-1:0]   b_sel;
  logic [1:0]        mode_sel;
  logic [NB_SUM-1:0] sum_in;
  s1_t               s1_q;
  logic              s1_vld;
  logic [NB_OUT-1:0] fmt_result;
  logic              fmt_ovf;

  assign stall = o_valid & ~i_out_ready;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) ptr <= PREF_0;
    else         ptr <= ptr_nxt;
  end

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    ptr_nxt = ptr;
    if (i_valid0 && (!i_valid1 || ptr == PREF_0)) grant0 = 1'b1;
    else if (i_valid1)                            grant1 = 1'b1;
    accept = (grant0 | grant1) & ~stall;
    if (accept) ptr_nxt = grant0 ? PREF_1 : PREF_0;
  end

  assign o_ready0 = grant0 & ~stall;
  assign o_ready1 = grant1 & ~stall;

  assign a_sel    = grant1 ? i_a1 : i_a0;
  assign b_sel    = grant1 ? i_b1 : i_b0;
  assign mode_sel = grant1 ? i_mode1 : i_mode0;
  // B has fewer fraction bits; shifting left lines its binary point up with A's.
  assign b_al     = {b_sel, {SHIFT_B{1'b0}}};
  assign sum_in   = {a_sel[NB_A-1], a_sel} + {b_al[NB_A-1], b_al};

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) s1_q <= '{sum: sum_in, mode: mode_sel, id: grant1};
    end
  end

  fp_fmt_sat u_fmt (
    .sum    (s1_q.sum),
    .mode   (s1_q.mode),
    .result (fmt_result),
    .ovf    (fmt_ovf)
  );

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_full   <= '0;
      o_ovf    <= 1'b0;
      o_id     <= 1'b0;
    end else if (!stall) begin
      o_valid <= s1_vld;
      if (s1_vld) begin
        o_result <= fmt_result;
        o_full   <= s1_q.sum;
        o_ovf    <= fmt_ovf;
        o_id     <= s1_q.id;
      end
    end
  end

`ifdef FP_SUM_STATS_EN
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_ovf_cnt <= '0;
    end else if (o_valid && i_out_ready && o_ovf && !(&o_ovf_cnt)) begin
      o_ovf_cnt <= o_ovf_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fp_sum_sched.sv
// Scoreboard bench for fp_sum_sched: directed test-plan vectors plus randomized traffic and backpressure.
// Expected results come from an integer-arithmetic model of the formatting rules.
module tb_fp_sum_sched;
  import fp_sum_pkg::*;

  logic              clock = 1'b0;
  logic              i_reset;
  logic              i_valid0, i_valid1, o_ready0, o_ready1;
  logic [NB_A-1:0]   i_a0, i_a1;
  logic [NB_B-1:0]   i_b0, i_b1;
  logic [1:0]        i_mode0, i_mode1;
  logic              o_valid, i_out_ready;
  logic [NB_OUT-1:0] o_result;
  logic [NB_SUM-1:0] o_full;
  logic              o_ovf, o_id;
`ifdef FP_SUM_STATS_EN
  logic [15:0]       o_ovf_cnt;
`endif

  always #5 clock = ~clock;

  fp_sum_sched dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_valid0    (i_valid0),
    .i_valid1    (i_valid1),
    .o_ready0    (o_ready0),
    .o_ready1    (o_ready1),
    .i_a0        (i_a0),
    .i_a1        (i_a1),
    .i_b0        (i_b0),
    .i_b1        (i_b1),
    .i_mode0     (i_mode0),
    .i_mode1     (i_mode1),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_full      (o_full),
    .o_ovf       (o_ovf),
`ifdef FP_SUM_STATS_EN
    .o_ovf_cnt   (o_ovf_cnt),
`endif
    .o_id        (o_id)
  );

  typedef struct {int a; int b; int mode;} req_t;
  typedef struct {int res; int full; int ovf; int id; int acc_cyc;} exp_t;

  req_t pend0[$], pend1[$];
  exp_t sb[$];
  req_t cur0, cur1;
  bit   cur_v0, cur_v1, acc0, acc1;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, mptr = 0, last_stall = -1, model_cnt = 0;
  bit   prev_stall = 0;
  int   held = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int fdiv16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  // Reference: exact integer value of A + B, scaled to 2^-14 units, then floor/round to 2^-10.
  function automatic exp_t model(input req_t q, input int id, input int c);
    exp_t e;
    int   sum, t, r, sel;
    sum = q.a + q.b * 16;
    t   = fdiv16(sum);
    r   = fdiv16(sum + 8);
    sel = (q.mode >= 2) ? r : t;
    e.ovf = (sel > 1023 || sel < -1024) ? 1 : 0;
    if (q.mode == 0) begin
      e.res = ((t % 2048) + 2048) % 2048;
      if (e.res >= 1024) e.res -= 2048;
    end else if (e.ovf != 0) begin
      e.res = (sel < 0) ? -1024 : 1023;
    end else begin
      e.res = sel;
    end
    e.full = sum;
    e.id = id;
    e.acc_cyc = c;
    return e;
  endfunction

  function automatic int pack_out();
    return int'({o_valid, o_id, o_ovf, o_full, o_result});
  endfunction

  // Driver: each requester holds its pair until accepted, then loads the next from its queue.
  initial begin
    i_valid0 = 0; i_valid1 = 0;
    i_a0 = '0; i_a1 = '0; i_b0 = '0; i_b1 = '0; i_mode0 = '0; i_mode1 = '0;
    forever begin
      @(posedge clock);
      #1;
      if (i_reset) begin
        cur_v0 = 0; cur_v1 = 0; acc0 = 0; acc1 = 0;
      end else begin
        if (cur_v0 && acc0) cur_v0 = 0;
        if (cur_v1 && acc1) cur_v1 = 0;
        acc0 = 0; acc1 = 0;
        if (!cur_v0 && pend0.size() > 0) begin cur0 = pend0.pop_front(); cur_v0 = 1; end
        if (!cur_v1 && pend1.size() > 0) begin cur1 = pend1.pop_front(); cur_v1 = 1; end
      end
      i_valid0 = cur_v0; i_a0 = 16'(cur0.a); i_b0 = 12'(cur0.b); i_mode0 = 2'(cur0.mode);
      i_valid1 = cur_v1; i_a1 = 16'(cur1.a); i_b1 = 12'(cur1.b); i_mode1 = 2'(cur1.mode);
    end
  end

  // Monitor: checks grants against a model arbiter, pushes expectations, pops on output handshakes.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (i_reset) begin
        prev_stall = 0;
      end else begin
        bit stall, eg0, eg1;
        stall = o_valid && !i_out_ready;
        eg0 = i_valid0 && (!i_valid1 || mptr == 0);
        eg1 = i_valid1 && !eg0;
        if (prev_stall) check("stall_hold", pack_out(), held);
        check("ready0", int'(o_ready0), int'(eg0 && !stall));
        check("ready1", int'(o_ready1), int'(eg1 && !stall));
`ifdef FP_SUM_STATS_EN
        check("ovf_cnt", int'(o_ovf_cnt), model_cnt);
`endif
        if (o_valid && i_out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", int'($signed(o_result)), e.res);
            check("full", int'($signed(o_full)), e.full);
            check("ovf", int'(o_ovf), e.ovf);
            check("id", int'(o_id), e.id);
            if (last_stall < e.acc_cyc) check("latency", cyc - e.acc_cyc, 2);
            if (e.ovf != 0 && model_cnt < 65535) model_cnt++;
          end
        end
        if (eg0 && !stall) begin
          sb.push_back(model('{int'($signed(i_a0)), int'($signed(i_b0)), int'(i_mode0)}, 0, cyc));
          mptr = 1; acc0 = 1;
        end else if (eg1 && !stall) begin
          sb.push_back(model('{int'($signed(i_a1)), int'($signed(i_b1)), int'(i_mode1)}, 1, cyc));
          mptr = 0; acc1 = 1;
        end
        if (stall) last_stall = cyc;
        prev_stall = stall;
        held = pack_out();
      end
    end
  end

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clock);
      #3;
      done = (sb.size() == 0 && pend0.size() == 0 && pend1.size() == 0 && !cur_v0 && !cur_v1);
    end
    check({name, "_drain"}, int'(done), 1);
  endtask

  task automatic push(input int req, input int a, input int b, input int mode);
    req_t q;
    q = '{a, b, mode};
    if (req == 0) pend0.push_back(q);
    else          pend1.push_back(q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1;
    i_out_ready = 1;
    #2;
    check("rst_valid", int'(o_valid), 0);
    check("rst_result", int'(o_result), 0);
    check("rst_full", int'(o_full), 0);
    check("rst_ovf", int'(o_ovf), 0);
    check("rst_id", int'(o_id), 0);
`ifdef FP_SUM_STATS_EN
    check("rst_cnt", int'(o_ovf_cnt), 0);
`endif
    repeat (2) @(posedge clock);
    #2 i_reset = 0;

    for (int m = 0; m < 3; m++) push(0, 28672, 512, m);
    wait_drain("req0_pos_ovf");
    for (int m = 0; m < 3; m++) push(1, 1000, 3, m);
    wait_drain("req1_round");
    for (int m = 0; m < 3; m++) push(0, -32768, -2048, m);
    wait_drain("neg_ovf");

    // Backpressure: hold the consumer off for 3 cycles once a result is showing.
    for (int i = 0; i < 3; i++) push(0, 1000 + i * 100, -7 * i, i);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clock);
        #1;
        seen = o_valid;
      end
      check("stall_prep_valid", int'(seen), 1);
    end
    i_out_ready = 0;
    repeat (3) @(posedge clock);
    #1 i_out_ready = 1;
    wait_drain("stall");

    // Reset with results in flight.
    for (int i = 0; i < 3; i++) push(1, 28672, 512, 1);
    repeat (4) @(posedge clock);
    #2;
    check("inflight_valid", int'(o_valid), 1);
    i_reset = 1;
    #1;
    check("midrst_valid", int'(o_valid), 0);
`ifdef FP_SUM_STATS_EN
    check("midrst_cnt", int'(o_ovf_cnt), 0);
`endif
    sb.delete(); pend0.delete(); pend1.delete();
    cur_v0 = 0; cur_v1 = 0; acc0 = 0; acc1 = 0;
    mptr = 0; model_cnt = 0;
    @(posedge clock);
    #2 i_reset = 0;

    // Both requesters valid back to back: pointer starts at 0 after reset.
    for (int i = 0; i < 3; i++) begin
      push(0, 100 * i, 5, 0);
      push(1, -100 * i, -5, 2);
    end
    wait_drain("alternate");

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra;
      logic [11:0] rb;
      ra = 16'($urandom);
      rb = 12'($urandom);
      if (i % 10 == 0) ra = (i % 20 == 0) ? 16'h7FFF : 16'h8000;
      push(int'($urandom_range(0, 1)), int'($signed(ra)), int'($signed(rb)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 2000 && (pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0); i++) begin
      @(posedge clock);
      #1 i_out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock);
    #1 i_out_ready = 1;
    wait_drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
